mem_xor_copy: RTL and testbench

Memory-side initiator for the 8-bit data memory port. On `start` it reads `len` bytes from `src_addr`, XORs each with an 8-bit key, and writes the result to `dst_addr`. It drives the memory port's `mem_read`/`mem_write`/address/write-data signals and consumes its combinational read data. It sits beside the core as a crypto copy engine for bulk whitening and un-whitening of buffers.

---
 rtl/mem_xor_copy.sv | 161 ++++++++++++++++
 tb/tb_mem_xor_copy.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xor_copy.sv
`default_nettype none
// ============================================================================
// Module   : mem_xor_copy
// Purpose  : Memory-side XOR copy engine. On an accepted start it reads len
//            bytes from src_addr, XORs each with a working key, and writes
//            the result to dst_addr. Each byte takes one READ cycle and one
//            WRITE cycle.
// Ports    : clk, rst_n (async, active-low)
//            i_start, i_src_addr, i_dst_addr, i_len, i_key : job request
//            o_busy, o_done                                : status
//            o_mem_read, o_mem_write, o_mem_address,
//            o_mem_write_data, i_mem_read_data             : memory port
//            o_checksum : 8-bit sum of written bytes (XCOPY_CHECKSUM_EN only)
// Params   : KEY_ROT - nonzero rotates the working key left by 1 after
//            each written byte
// Config   : XCOPY_CHECKSUM_EN - adds o_checksum and its accumulator
// Revision : 1.0 - initial release
// ============================================================================
module mem_xor_copy #(
  parameter int KEY_ROT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_src_addr,
  input  logic [7:0] i_dst_addr,
  input  logic [7:0] i_len,
  input  logic [7:0] i_key,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic [7:0] o_mem_address,
  output logic [7:0] o_mem_write_data,
  input  logic [7:0] i_mem_read_data
`ifdef XCOPY_CHECKSUM_EN
  ,
  output logic [7:0] o_checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_wkey;
  logic [7:0] r_buf;

  logic [7:0] w_idx_next;
  logic       w_more;
  logic [7:0] w_wkey_next;

  assign w_idx_next  = r_idx + 8'd1;
  // 9-bit compare so idx+1 never wraps before being tested against len
  assign w_more      = ({1'b0, r_idx} + 9'd1) < {1'b0, r_len};
  assign w_wkey_next = (KEY_ROT != 0) ? {r_wkey[6:0], r_wkey[7]} : r_wkey;

  // Write data is a pure decode of registers; the write strobe gates it to
  // zero outside WRITE (and during reset, since the strobe is reset).
  assign o_mem_write_data = o_mem_write ? (r_buf ^ r_wkey) : 8'h00;

`ifdef XCOPY_CHECKSUM_EN
  logic [7:0] r_checksum;
  assign o_checksum = r_checksum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_src         <= 8'h00;
      r_dst         <= 8'h00;
      r_len         <= 8'h00;
      r_idx         <= 8'h00;
      r_wkey        <= 8'h00;
      r_buf         <= 8'h00;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_address <= 8'h00;
`ifdef XCOPY_CHECKSUM_EN
      r_checksum    <= 8'h00;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_busy        <= 1'b0;
          o_mem_read    <= 1'b0;
          o_mem_write   <= 1'b0;
          o_mem_address <= 8'h00;
          if (i_start) begin
            r_src  <= i_src_addr;
            r_dst  <= i_dst_addr;
            r_len  <= i_len;
            r_idx  <= 8'h00;
            r_wkey <= i_key;
`ifdef XCOPY_CHECKSUM_EN
            r_checksum <= 8'h00;
`endif
            if (i_len != 8'h00) begin
              // Registered outputs: present the first READ address now
              r_state       <= S_READ;
              o_busy        <= 1'b1;
              o_mem_read    <= 1'b1;
              o_mem_address <= i_src_addr;
            end else begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end
          end
        end

        S_READ: begin
          r_buf         <= i_mem_read_data;
          r_state       <= S_WRITE;
          o_mem_read    <= 1'b0;
          o_mem_write   <= 1'b1;
          o_mem_address <= r_dst + r_idx;
        end

        S_WRITE: begin
          r_idx       <= w_idx_next;
          r_wkey      <= w_wkey_next;
          o_mem_write <= 1'b0;
`ifdef XCOPY_CHECKSUM_EN
          r_checksum  <= r_checksum + o_mem_write_data;
`endif
          if (w_more) begin
            r_state       <= S_READ;
            o_mem_read    <= 1'b1;
            o_mem_address <= r_src + w_idx_next;
          end else begin
            r_state       <= S_DONE;
            o_busy        <= 1'b0;
            o_done        <= 1'b1;
            o_mem_address <= 8'h00;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_xor_copy.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_xor_copy
// Purpose  : Self-checking bench for mem_xor_copy. Two instances (constant
//            key and rotating key) run the same jobs against their own
//            memories. A byte-level model predicts every cycle's outputs;
//            a compare process checks them each cycle, and literal
//            expectations pin the model on the documented scenarios.
// Config   : XCOPY_CHECKSUM_EN - also checks o_checksum
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_xor_copy;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_src_addr = 8'h00;
  logic [7:0] i_dst_addr = 8'h00;
  logic [7:0] i_len = 8'h00;
  logic [7:0] i_key = 8'h00;

  logic       busy0, done0, mr0, mw0;
  logic [7:0] ma0, mwd0, mrd0;
  logic       busy1, done1, mr1, mw1;
  logic [7:0] ma1, mwd1, mrd1;
`ifdef XCOPY_CHECKSUM_EN
  logic [7:0] ck0, ck1;
`endif

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] mm0  [256];
  logic [7:0] mm1  [256];

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ck;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] lastck0 = 8'h00;
  logic [7:0] lastck1 = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_xor_copy #(.KEY_ROT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len), .i_key(i_key),
    .o_busy(busy0), .o_done(done0), .o_mem_read(mr0), .o_mem_write(mw0),
    .o_mem_address(ma0), .o_mem_write_data(mwd0), .i_mem_read_data(mrd0)
`ifdef XCOPY_CHECKSUM_EN
    , .o_checksum(ck0)
`endif
  );

  mem_xor_copy #(.KEY_ROT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len), .i_key(i_key),
    .o_busy(busy1), .o_done(done1), .o_mem_read(mr1), .o_mem_write(mw1),
    .o_mem_address(ma1), .o_mem_write_data(mwd1), .i_mem_read_data(mrd1)
`ifdef XCOPY_CHECKSUM_EN
    , .o_checksum(ck1)
`endif
  );

  // Combinational-read, edge-write memories
  assign mrd0 = mem0[ma0];
  assign mrd1 = mem1[ma1];
  always @(posedge clk) begin
    if (mw0) mem0[ma0] <= mwd0;
    if (mw1) mem1[ma1] <= mwd1;
  end

  task automatic setb(input logic [7:0] a, input logic [7:0] v);
    mem0[a] = v; mem1[a] = v; mm0[a] = v; mm1[a] = v;
  endtask

  // Byte-level model: expected output per cycle after the accepting edge
  task automatic build(input int inst, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] k);
    logic [7:0] scr [256];
    logic [7:0] wk, ck, rv, wv, a;
    exp_t e;
    for (int j = 0; j < 256; j++) scr[j] = (inst == 0) ? mm0[j] : mm1[j];
    wk = k;
    ck = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      a  = s + 8'(i);
      rv = scr[a];
      wv = rv ^ wk;
      e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = a; e.ck = ck;
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      a = d + 8'(i);
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = a; e.wdata = wv; e.ck = ck;
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      scr[a] = wv;
      ck = ck + wv;
      if (inst == 1) wk = {wk[6:0], wk[7]};
    end
    e = '0; e.done = 1'b1; e.ck = ck;
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic chk(input int inst, input logic [19:0] act
`ifdef XCOPY_CHECKSUM_EN
                     , input logic [7:0] actck
`endif
                    );
    exp_t e;
    logic [19:0] ex;
    e = '0;
    if (inst == 0) begin
      if (q0.size() > 0) e = q0.pop_front(); else e.ck = lastck0;
      lastck0 = e.ck;
    end else begin
      if (q1.size() > 0) e = q1.pop_front(); else e.ck = lastck1;
      lastck1 = e.ck;
    end
    ex = {e.busy, e.done, e.rd, e.wr, e.addr, e.wdata};
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL outputs inst%0d t=%0t: got busy,done,rd,wr,addr,wdata=%h required %h",
               inst, $time, act, ex);
    end
    total++;
    if (act[17] && act[16]) begin
      bad++;
      $display("FAIL rd_wr_exclusive inst%0d t=%0t: got rd=1 wr=1 required not both", inst, $time);
    end
`ifdef XCOPY_CHECKSUM_EN
    total++;
    if (actck !== e.ck) begin
      bad++;
      $display("FAIL checksum inst%0d t=%0t: got %h required %h", inst, $time, actck, e.ck);
    end
`endif
    if (e.wr) begin
      if (inst == 0) mm0[e.addr] = e.wdata; else mm1[e.addr] = e.wdata;
    end
  endtask

  always @(posedge clk) begin
    #1;
`ifdef XCOPY_CHECKSUM_EN
    chk(0, {busy0, done0, mr0, mw0, ma0, mwd0}, ck0);
    chk(1, {busy1, done1, mr1, mw1, ma1, mwd1}, ck1);
`else
    chk(0, {busy0, done0, mr0, mw0, ma0, mwd0});
    chk(1, {busy1, done1, mr1, mw1, ma1, mwd1});
`endif
  end

  task automatic expect8(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in the IDLE cycle after DONE
  task automatic run_job(input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] k);
    int c;
    i_src_addr = s; i_dst_addr = d; i_len = l; i_key = k; i_start = 1'b1;
    build(0, s, d, l, k);
    build(1, s, d, l, k);
    @(posedge clk);
    #1 i_start = 1'b0;
    #1;
    c = 1;
    while (!done0 && c < 600) begin
      @(posedge clk);
      #2;
      c++;
    end
    total++;
    if (c != 2 * int'(l) + 1 || !done1) begin
      bad++;
      $display("FAIL done_cycle len=%0d: got cycle %0d (done1=%b) required cycle %0d",
               l, c, done1, 2 * int'(l) + 1);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [7:0] orig0 [16];
  logic [7:0] orig1 [16];
  logic [7:0] exp4  [4];
  logic [7:0] exp3  [3];
  logic [7:0] r8    [3];
  int nerr;

  initial begin
    for (int j = 0; j < 256; j++) setb(8'(j), 8'($urandom));

    // Reset state, before any clock edge
    #2;
    expect8("reset_outputs0", {4'h0, busy0, done0, mr0, mw0}, 8'h00);
    expect8("reset_addr0", ma0, 8'h00);
    expect8("reset_wdata1", mwd1, 8'h00);
`ifdef XCOPY_CHECKSUM_EN
    expect8("reset_checksum0", ck0, 8'h00);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy
    setb(8'h10, 8'h11); setb(8'h11, 8'h22); setb(8'h12, 8'h33); setb(8'h13, 8'h44);
    run_job(8'h10, 8'h80, 8'd4, 8'hFF);
    exp4 = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
    for (int i = 0; i < 4; i++) begin
      expect8("basic_dst0", mem0[8'h80 + 8'(i)], exp4[i]);
      expect8("basic_dst1", mem1[8'h80 + 8'(i)], exp4[i]);
    end
    expect8("basic_src_kept", mem0[8'h12], 8'h33);
`ifdef XCOPY_CHECKSUM_EN
    expect8("basic_checksum", ck0, 8'h52);
`endif

    // Wrap-around
    setb(8'hFE, 8'hA1); setb(8'hFF, 8'hB2); setb(8'h00, 8'hC3);
    run_job(8'hFE, 8'h40, 8'd3, 8'h00);
    exp3 = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) expect8("wrap_dst0", mem0[8'h40 + 8'(i)], exp3[i]);

    // Key rotation (instance 1) vs constant key (instance 0)
    setb(8'h00, 8'h00); setb(8'h01, 8'h00); setb(8'h02, 8'h00);
    run_job(8'h00, 8'h20, 8'd3, 8'h81);
    exp3 = '{8'h81, 8'h03, 8'h06};
    for (int i = 0; i < 3; i++) begin
      expect8("rot_dst1", mem1[8'h20 + 8'(i)], exp3[i]);
      expect8("norot_dst0", mem0[8'h20 + 8'(i)], 8'h81);
    end

    // Zero length: DONE in cycle 1, model expects no strobes
    run_job(8'h33, 8'h44, 8'd0, 8'h77);

    // Start pulsed during WRITE of a len=2 job is ignored
    fork
      run_job(8'h50, 8'h58, 8'd2, 8'hA5);
      begin
        @(negedge clk); @(negedge clk);
        i_start = 1'b1; i_src_addr = 8'($urandom); i_dst_addr = 8'($urandom);
        i_len = 8'd9; i_key = 8'($urandom);
        @(negedge clk);
        i_start = 1'b0;
      end
    join

    // Reset mid-transfer: in-place XOR 0x5A over 8 bytes, reset in cycle 5
    for (int i = 0; i < 3; i++) r8[i] = mem0[8'h60 + 8'(i)];
    i_src_addr = 8'h60; i_dst_addr = 8'h60; i_len = 8'd8; i_key = 8'h5A; i_start = 1'b1;
    build(0, 8'h60, 8'h60, 8'd8, 8'h5A);
    build(1, 8'h60, 8'h60, 8'd8, 8'h5A);
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    q0.delete(); q1.delete();
    lastck0 = 8'h00; lastck1 = 8'h00;
    #1;
    expect8("async_reset_strobes", {busy0, done0, mr0, mw0, busy1, done1, mr1, mw1}, 8'h00);
    expect8("async_reset_addr", ma0 | ma1, 8'h00);
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect8("abort_byte0", mem0[8'h60], r8[0] ^ 8'h5A);
    expect8("abort_byte1", mem0[8'h61], r8[1] ^ 8'h5A);
    expect8("abort_byte2_kept", mem0[8'h62], r8[2]);
    run_job(8'h60, 8'hA0, 8'd5, 8'h5A);

    // In-place round trip with XOR 0x3C
    for (int i = 0; i < 16; i++) begin
      orig0[i] = mem0[i];
      orig1[i] = mem1[i];
    end
    run_job(8'h00, 8'h00, 8'd16, 8'h3C);
    run_job(8'h00, 8'h00, 8'd16, 8'h3C);
    for (int i = 0; i < 16; i++) begin
      expect8("roundtrip0", mem0[i], orig0[i]);
      expect8("roundtrip1", mem1[i], orig1[i]);
    end

    // Randomized jobs, including overlapping regions
    for (int n = 0; n < 24; n++) begin
      run_job(8'($urandom), 8'($urandom), 8'($urandom_range(0, 40)), 8'($urandom));
    end

    // Whole memories against the model
    nerr = 0;
    for (int j = 0; j < 256; j++) if (mem0[j] !== mm0[j] || mem1[j] !== mm1[j]) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL final_memory: got %0d differing bytes required 0", nerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
